// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide controller.
// Optional divider support is selected elsewhere with the MDU_DIV_EN macro.
package mdu_pkg;

    localparam int MDU_W = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } mdu_state_e;

    function automatic logic isSignedOp(input mdu_op_e opSel);
        return (opSel == MDU_MULT) || (opSel == MDU_DIV);
    endfunction

    function automatic logic isDivOp(input mdu_op_e opSel);
        return (opSel == MDU_DIV) || (opSel == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the shared datapath: shift-add for multiply,
// restoring shift-subtract for divide. The divide path is only exercised under MDU_DIV_EN.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int W = MDU_W
) (
    input  logic           isDiv,
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   operand,
    output logic [2*W-1:0] accNext
);

    logic [W:0] sum;
    logic [W:0] shifted;
    logic [W:0] diff;

    // Multiply keeps {partial product, remaining multiplier bits}; divide keeps {remainder, quotient}.
    always_comb begin
        sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
        shifted = {acc[2*W-1:W], acc[W-1]};
        diff    = shifted - {1'b0, operand};
        accNext = {sum, acc[W-1:1]};
        if (isDiv) begin
            if (diff[W]) begin
                accNext = {shifted[W-1:0], acc[W-2:0], 1'b0};
            end else begin
                accNext = {diff[W-1:0], acc[W-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU controller with held HI/LO result registers.
// Define MDU_DIV_EN to build the divider; otherwise divide requests finish early with err.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, accStep;
    logic [CW-1:0]      count_q, count_d;
    logic               negLo_q, negLo_d;
    logic               err_q, err_d;
`ifdef MDU_DIV_EN
    logic               negRem_q, negRem_d;
`endif

    logic               stepIsDiv;
    logic               aNeg, bNeg;
    logic [WIDTH-1:0]   absA, absB;
    logic [2*WIDTH-1:0] product;

`ifdef MDU_DIV_EN
    assign stepIsDiv = isDivOp(op_q);
`else
    assign stepIsDiv = 1'b0;
`endif

    mdu_step #(.W(WIDTH)) u_step (
        .isDiv   (stepIsDiv),
        .acc     (acc_q),
        .operand (opnd_q),
        .accNext (accStep)
    );

    // Signed ops iterate on magnitudes; signs are reapplied in FIX.
    always_comb begin
        aNeg    = isSignedOp(op_q) && a_q[WIDTH-1];
        bNeg    = isSignedOp(op_q) && b_q[WIDTH-1];
        absA    = aNeg ? -a_q : a_q;
        absB    = bNeg ? -b_q : b_q;
        product = negLo_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        count_d = count_q;
        negLo_d = negLo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
`ifdef MDU_DIV_EN
        negRem_d = negRem_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = mdu_op_e'(op);
                    a_d     = a;
                    b_d     = b;
                    err_d   = 1'b0;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                count_d = '0;
                negLo_d = aNeg ^ bNeg;
                if (!isDivOp(op_q)) begin
                    acc_d   = {{WIDTH{1'b0}}, absB};
                    opnd_d  = absA;
                    state_d = S_RUN;
                end
`ifdef MDU_DIV_EN
                else if (b_q == '0) begin
                    lo_d    = '1;
                    hi_d    = a_q;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    acc_d    = {{WIDTH{1'b0}}, absA};
                    opnd_d   = absB;
                    negRem_d = aNeg;
                    state_d  = S_RUN;
                end
`else
                else begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_RUN: begin
                acc_d   = accStep;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d      = S_DONE;
                {hi_d, lo_d} = product;
`ifdef MDU_DIV_EN
                if (isDivOp(op_q)) begin
                    lo_d = negLo_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                    hi_d = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= MDU_MULT;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            negLo_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            err_q    <= 1'b0;
`ifdef MDU_DIV_EN
            negRem_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            negLo_q  <= negLo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            err_q    <= err_d;
`ifdef MDU_DIV_EN
            negRem_q <= negRem_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign err  = err_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl against an arithmetic reference model.
// Expectations follow the MDU_DIV_EN setting of the build.
module tb_mdu_ctrl;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy, done, err;
    logic [31:0] hi, lo;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;
    logic [1:0]  curOp;
    logic [31:0] curA, curB;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .hi    (hi),
        .lo    (lo)
    );

    // Expected results from plain integer arithmetic; latency counted from the accept cycle.
    function automatic void refModel(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                     input logic [31:0] pHi, input logic [31:0] pLo,
                                     output logic [31:0] eHi, output logic [31:0] eLo,
                                     output logic eErr, output int eLat);
        longint      sa, sb;
        logic [63:0] p;
        sa   = longint'($signed(ma));
        sb   = longint'($signed(mb));
        eErr = 1'b0;
        eLat = 35;
        eHi  = pHi;
        eLo  = pLo;
        case (mop)
            2'b00: begin
                p = 64'(sa * sb);
                {eHi, eLo} = p;
            end
            2'b01: begin
                p = {32'b0, ma} * {32'b0, mb};
                {eHi, eLo} = p;
            end
            default: begin
`ifdef MDU_DIV_EN
                if (mb == 32'd0) begin
                    eErr = 1'b1;
                    eLat = 2;
                    eHi  = ma;
                    eLo  = 32'hFFFF_FFFF;
                end else if (mop == 2'b11) begin
                    eLo = ma / mb;
                    eHi = ma % mb;
                end else begin
                    eLo = 32'(sa / sb);
                    eHi = 32'(sa % sb);
                end
`else
                eErr = 1'b1;
                eLat = 2;
`endif
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Holds start for exactly one cycle; returns at the falling edge of cycle t+1.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        curOp = o;
        curA  = x;
        curB  = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done, optionally pulsing a stray start at cycle t+intrudeAt.
    task automatic checkOutput(input string tag, input int intrudeAt);
        int          k;
        int          busyLow;
        logic [31:0] eHi, eLo;
        logic        eErr;
        int          eLat;
        refModel(curOp, curA, curB, modelHi, modelLo, eHi, eLo, eErr, eLat);
        k       = 1;
        busyLow = 0;
        while (!done && k < 60) begin
            if (!busy) busyLow++;
            if (k == intrudeAt) begin
                start = 1'b1;
                op    = ~curOp;
                a     = $urandom;
                b     = $urandom;
            end
            @(negedge clk);
            start = 1'b0;
            k++;
        end
        check({tag, " latency"}, 64'(k), 64'(eLat));
        check({tag, " busyLow"}, 64'(busyLow), 64'd0);
        check({tag, " busyAtDone"}, 64'(busy), 64'd1);
        check({tag, " err"}, 64'(err), 64'(eErr));
        check({tag, " hi"}, 64'(hi), 64'(eHi));
        check({tag, " lo"}, 64'(lo), 64'(eLo));
        modelHi = eHi;
        modelLo = eLo;
    endtask

    initial begin
        int dones;
        logic [31:0] ra, rb;
        logic [1:0]  ro;

        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("multu max", 0);
        applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd7);
        checkOutput("mult neg", 0);
        applyStimulus(2'b11, 32'd7, 32'd2);
        checkOutput("divu 7/2", 0);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div -7/2", 0);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div ovf", 0);
        applyStimulus(2'b11, 32'd5, 32'd0);
        checkOutput("divu by0", 0);
        applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000);
        checkOutput("mult minmin", 0);

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            applyStimulus(ro, ra, rb);
            checkOutput($sformatf("rand%0d op%0d", i, ro), 0);
        end

        applyStimulus(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        checkOutput("start in run", 10);

        $display("[TB] reset during RUN at counter 10");
        applyStimulus(2'b00, $urandom, $urandom);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort err", 64'(err), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        rst_n   = 1'b1;
        modelHi = '0;
        modelLo = '0;
        dones   = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort no done", 64'(dones), 64'd0);

        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
        checkOutput("after abort", 0);
        applyStimulus(2'b10, 32'd100, 32'hFFFF_FFF9);
        checkOutput("back2back", 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Iterative multiply/divide controller for the multicycle 54-instruction CPU. Accepts MULT/MULTU/DIV/DIVU requests from the main control FSM, sequences a shared shift-add/shift-subtract datapath over WIDTH iterations, and loads the 64-bit result into held HI/LO registers. HI/LO keep their value between operations, so the datapath reads them in any later cycle. Sits beside the ALU; its outputs feed the MFHI/MFLO source mux.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  multiplicand / dividend; sampled with start
- b  in  WIDTH  multiplier / divisor; sampled with start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; HI/LO valid from this cycle on
- err  out  1  high with done on divide-by-zero or an unsupported op
- hi  out  WIDTH  high product word / remainder
- lo  out  WIDTH  low product word / quotient

## Operation
- Reset (rst_n=0 at an edge), including mid-operation:
  - state→IDLE, iteration counter cleared.
  - busy=0, done=0, err=0, hi=0, lo=0.
  - No done pulse is produced for the aborted operation.
- FSM states: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - If start=1, latch op, a and b, then go to PREP.
  - start is ignored in every other state; there is no queueing.
- PREP:
  - Signed ops (MULT, DIV): take absolute values and record the result signs.
    - Product sign is a[W-1]^b[W-1].
    - Quotient sign is a[W-1]^b[W-1]; remainder sign is a[W-1].
  - Divide with b=0: go to DONE and set lo=all-ones, hi=a, err=1.
  - Otherwise go to RUN with counter=0.
- RUN: exactly WIDTH cycles, one iteration per cycle, counter 0..WIDTH-1; on the last iteration go to FIX.
  - Multiply: unsigned shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract; partial remainder is WIDTH+1 bits wide.
- FIX: apply two's-complement negation to the magnitude results per the recorded signs, then go to DONE.
- DONE:
  - hi/lo registers are written on entry to DONE.
  - done=1 for this single cycle; then go to IDLE.
- Arithmetic rules:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH-bit product.
  - DIV truncates toward zero.
  - Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, err=0).
- hi/lo/err hold their last value until the next DONE or reset; err is cleared on the next accepted start.

## Timing
- Accept edge: start=1 in IDLE during cycle t.
- Normal completion: done=1 in cycle t+WIDTH+3 (t+35 at WIDTH=32).
- Divide-by-zero / unsupported: done=1 in cycle t+2.
- busy: high from cycle t+1 through the done cycle inclusive.
- Earliest next accept: start in the cycle after done.

## Configuration
- MDU_DIV_EN defined:
  - Divider path, b=0 detection and the DIV/DIVU FIX logic are compiled in.
- MDU_DIV_EN undefined:
  - DIV/DIVU skip RUN: PREP→DONE with done at t+2, err=1.
  - hi/lo remain unchanged.
  - Multiply behaviour and latency are identical to the divider-enabled build.

## Structure
- Package mdu_pkg:
  - op encoding enum (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU).
  - state enum.
  - MDU_W default constant.
- Sub-module mdu_step: combinational single iteration.
  - Inputs: op class, accumulator/partial remainder, operand.
  - Output: next accumulator.
  - Instantiated once inside mdu_ctrl; FSM, counter and HI/LO registers stay in mdu_ctrl.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done at t+35, hi=0xFFFFFFFE, lo=0x00000001, err=0.
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIVU 7/2 → lo=3, hi=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, err=0.
- DIVU a=5, b=0 → done at t+2, err=1, lo=0xFFFFFFFF, hi=5. Without MDU_DIV_EN, same stimulus → done at t+2, err=1, hi/lo unchanged.
- Mid-operation and protocol checks:
  - Pulse start during RUN: ignored.
  - Drive rst_n=0 at counter=10: next cycle busy=0, hi=lo=0, no done pulse.
  - Start in the cycle after done: accepted.
